vector_alu: RTL and testbench
=============================

Name: vector_alu

Overview:
- SIMD integer ALU for the interpolation ASIP vector datapath.
- Applies one operation lane-wise across LANES packed WIDTH-bit elements of two vector operands.
- Supports a conditional-subtract mode used by the interpolation kernels.
- Result is registered: one-cycle latency from operand capture to output.

Parameters:
- LANES, 8, number of vector lanes.
- WIDTH, 32, bits per lane; vector width is LANES*WIDTH (256 by default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands and opcode valid this cycle.
- vc_sub  input  1  conditional-subtract enable; affects opcode 001 only.
- alu_op  input  3  lane operation select.
- in_a  input  LANES*WIDTH  operand A; lane i occupies bits [i*WIDTH +: WIDTH].
- in_b  input  LANES*WIDTH  operand B; same packing as in_a.
- out  output  LANES*WIDTH  registered lane results; same packing.
- out_valid  output  1  out holds the result of the operation sampled on the previous edge.

Behaviour:
- Reset: when rst_n=0 at a rising clk, out<=0 and out_valid<=0.
- Reset has priority over in_valid.
- Latency: if in_valid=1 at edge N, the lane results appear on out and out_valid=1 after edge N.
- If in_valid=0, out holds its previous value and out_valid<=0.
- No backpressure; a new operation may be issued every cycle.
- Per lane i, with a=in_a lane i and b=in_b lane i, two's complement, result truncated to WIDTH bits:
  - 000: a+b, wraps modulo 2^WIDTH.
  - 001, vc_sub=0: a-b, wraps (100-103 gives 0xFFFFFFFD).
  - 001, vc_sub=1: a-b if signed(a) >= signed(b), else a unchanged. a==b gives 0.
  - 010: low WIDTH bits of a*b. Low bits are identical for signed and unsigned.
  - 011: a & b.
  - 100: a | b.
  - 101: a ^ b.
  - 110: a << b[4:0], logical, zero fill.
  - 111: a >> b[4:0], arithmetic, sign fill.
- vc_sub is ignored for every opcode other than 001.
- Lanes are fully independent: no carries or borrows cross lane boundaries.
- No X propagation from an unused opcode path.

Optional Feature:
- Macro: VALU_ZERO_FLAGS_EN.
- Defined:
  - Adds output port zero_flags, LANES bits wide.
  - Bit i is set when lane i's result is zero.
  - Registered together with out; cleared to 0 on reset; holds when in_valid=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and random operands -> out=0, out_valid=0. Release reset -> first result appears one cycle after the first valid edge.
- Multiply: A lanes 0..7 = 100..107, B lanes all 103, alu_op=010 -> lanes 10300, 10403, 10506, 10609, 10712, 10815, 10918, 11021.
- Subtract: same operands, alu_op=001, vc_sub=0 -> lanes -3, -2, -1, 0, 1, 2, 3, 4 (lane 0 = 0xFFFFFFFD).
- Conditional subtract: same operands, alu_op=001, vc_sub=1 -> lanes 100, 101, 102, 0, 1, 2, 3, 4.
- Wrap and lane isolation:
  - Add, lane0 A=0xFFFFFFFF, B=1, other lanes 0 -> lane0=0, lane1=0 (no carry into next lane).
  - Shift right, A=0x80000000, B=31, alu_op=111 -> 0xFFFFFFFF.
- Hold and back-to-back:
  - Issue mul then sub on consecutive cycles -> results on consecutive cycles.
  - Drop in_valid -> out holds the sub result and out_valid=0.
  - With VALU_ZERO_FLAGS_EN defined, the conditional-subtract case gives zero_flags=8'b00001000.

Source files
------------

// File: rtl/vector_alu.sv
// vector_alu: lane-wise SIMD integer ALU with a one-cycle registered result.
// Optional per-lane zero flags are enabled by defining VALU_ZERO_FLAGS_EN.
module vector_alu #(
   parameter int LANES = 8,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic                   vc_sub,
   input  logic [2:0]             alu_op,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   output logic [LANES*WIDTH-1:0] out,
   output logic                   out_valid
`ifdef VALU_ZERO_FLAGS_EN
   ,
   output logic [LANES-1:0]       zero_flags
`endif
);
   logic [LANES*WIDTH-1:0] res;
   logic [LANES-1:0]       zf_next;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH-1:0] a, b, prd, sra, sub, r;
      assign a = in_a[i*WIDTH +: WIDTH];
      assign b = in_b[i*WIDTH +: WIDTH];
      assign prd = a * b;
      // kept separate so the arithmetic shift stays signed
      assign sra = $signed(a) >>> b[4:0];
      assign sub = (vc_sub && ($signed(a) < $signed(b))) ? a : a - b;
      assign r = alu_op == 3'b000 ? a + b :
                 alu_op == 3'b001 ? sub :
                 alu_op == 3'b010 ? prd :
                 alu_op == 3'b011 ? a & b :
                 alu_op == 3'b100 ? a | b :
                 alu_op == 3'b101 ? a ^ b :
                 alu_op == 3'b110 ? a << b[4:0] : sra;
      assign res[i*WIDTH +: WIDTH] = r;
      assign zf_next[i] = r == '0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) out <= res;
      end
   end
`ifdef VALU_ZERO_FLAGS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) zero_flags <= '0;
      else if (in_valid) zero_flags <= zf_next;
   end
`else
   logic unused_zf;
   assign unused_zf = ^zf_next;
`endif
endmodule

// File: tb/tb_vector_alu.sv
// tb_vector_alu: directed and random checks of vector_alu against an arithmetic reference model.
module tb_vector_alu;
   localparam int LANES = 8;
   localparam int WIDTH = 32;
   localparam int VW = LANES * WIDTH;
   logic          clk = 0;
   logic          rst_n = 0;
   logic          in_valid = 0;
   logic          vc_sub = 0;
   logic [2:0]    alu_op = 0;
   logic [VW-1:0] in_a = 0, in_b = 0;
   logic [VW-1:0] out;
   logic          out_valid;
   logic [VW-1:0] exp_out = 0;
   logic          exp_valid = 0;
   int            checks = 0, failures = 0;
`ifdef VALU_ZERO_FLAGS_EN
   logic [LANES-1:0] zero_flags;
`endif
   vector_alu #(.LANES(LANES), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .vc_sub(vc_sub), .alu_op(alu_op),
      .in_a(in_a), .in_b(in_b), .out(out), .out_valid(out_valid)
`ifdef VALU_ZERO_FLAGS_EN
      , .zero_flags(zero_flags)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask
   function automatic logic [31:0] ref_lane(input logic [2:0] op, input logic vc, input logic [31:0] a, input logic [31:0] b);
      longint ua = longint'(a), ub = longint'(b), sa = longint'($signed(a)), sb = longint'($signed(b));
      longint p2 = longint'(1) << b[4:0];
      case (op)
         3'd0: return 32'(ua + ub);
         3'd1: return (vc && sa < sb) ? a : 32'(ua - ub);
         3'd2: return 32'(ua * ub);
         3'd3: return a & b;
         3'd4: return a | b;
         3'd5: return a ^ b;
         3'd6: return 32'(ua * p2);
         default: return 32'(sa >= 0 ? sa / p2 : (sa - (p2 - 1)) / p2);
      endcase
   endfunction
   function automatic logic [VW-1:0] ref_vec(input logic [2:0] op, input logic vc, input logic [VW-1:0] a, input logic [VW-1:0] b);
      logic [VW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*32 +: 32] = ref_lane(op, vc, a[i*32 +: 32], b[i*32 +: 32]);
      return r;
   endfunction
   function automatic logic [VW-1:0] lanes(input int base, input int step);
      logic [VW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*32 +: 32] = 32'(base + step * i);
      return r;
   endfunction
   task automatic compare(input string tag);
      check({tag, "_out"}, out, exp_out);
      check({tag, "_valid"}, VW'(out_valid), VW'(exp_valid));
`ifdef VALU_ZERO_FLAGS_EN
      begin
         logic [LANES-1:0] zf;
         for (int i = 0; i < LANES; i++) zf[i] = exp_out[i*32 +: 32] == 0;
         check({tag, "_zf"}, VW'(zero_flags), VW'(zf));
      end
`endif
   endtask
   task automatic drive(input logic v, input logic [2:0] op, input logic vc, input logic [VW-1:0] a, input logic [VW-1:0] b);
      in_valid = v; alu_op = op; vc_sub = vc; in_a = a; in_b = b;
      if (!rst_n) begin
         exp_out = 0; exp_valid = 0;
      end else begin
         exp_valid = v;
         if (v) exp_out = ref_vec(op, vc, a, b);
      end
   endtask
   task automatic step(input string tag);
      @(posedge clk);
      @(negedge clk);
      compare(tag);
   endtask
   logic [VW-1:0] a0, b0, lane0_max, one;
   initial begin
      a0 = lanes(100, 1);
      b0 = lanes(103, 0);
      rst_n = 0;
      drive(1, 3'd0, 0, {8{$urandom}}, {8{$urandom}});
      step("rst1");
      drive(1, 3'd2, 1, {8{$urandom}}, {8{$urandom}});
      step("rst2");
      check("rst_lit", out, '0);
      rst_n = 1;
      drive(1, 3'd2, 0, a0, b0);
      step("mul");
      check("mul_lit", out, {32'd11021, 32'd10918, 32'd10815, 32'd10712, 32'd10609, 32'd10506, 32'd10403, 32'd10300});
      drive(1, 3'd1, 0, a0, b0);
      step("sub");
      check("sub_lit", out, {32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD});
      drive(0, 3'd5, 1, {8{$urandom}}, {8{$urandom}});
      step("hold");
      check("hold_lit", out[31:0], VW'(32'hFFFFFFFD));
      drive(1, 3'd1, 1, a0, b0);
      step("csub");
      check("csub_lit", out, {32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd102, 32'd101, 32'd100});
`ifdef VALU_ZERO_FLAGS_EN
      check("csub_zf_lit", VW'(zero_flags), VW'(8'b00001000));
`endif
      lane0_max = '0; lane0_max[31:0] = 32'hFFFFFFFF;
      one = '0; one[31:0] = 32'd1;
      drive(1, 3'd0, 0, lane0_max, one);
      step("wrap");
      check("wrap_lit", out, '0);
      drive(1, 3'd7, 0, {8{32'h80000000}}, {8{32'd31}});
      step("sra");
      check("sra_lit", out, {8{32'hFFFFFFFF}});
      drive(1, 3'd6, 0, {8{32'hFFFFFFFF}}, {8{32'd31}});
      step("shl");
      check("shl_lit", out, {8{32'h80000000}});
      for (int n = 0; n < 400; n++) begin
         logic [VW-1:0] ra, rb;
         for (int i = 0; i < LANES; i++) begin
            ra[i*32 +: 32] = $urandom;
            rb[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? ra[i*32 +: 32] : $urandom;
         end
         rst_n = $urandom_range(0, 30) != 0;
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom), ra, rb);
         step("rand");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
